// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
// The head word is always presented on o_Data while the FIFO is non-empty.
// i_Read pops that head word.
//
// Optional feature macro: FIFO_DIAG_EN
//   - defined:   the diagnostic ports carry the live state and both pointers.
//   - undefined: the diagnostic ports are tied to 0.
//
// Ports:
//   i_Clk             clock; all state updates on the rising edge
//   i_Rst             asynchronous reset, active low
//   i_Data_Valid      write strobe; word taken when not full
//   i_Data            write data
//   i_Read            pop strobe; head removed when not empty
//   o_Full            DEPTH words stored
//   o_Empty           no words stored
//   o_Data            head word (asynchronous read of the array)
//   o_Diag_State      0=EMPTY, 1=PARTIAL, 2=FULL
//   o_Diag_Buf_W_Addr next write slot
//   o_Diag_Buf_R_Addr head slot
module sync_fifo #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DATA_WIDTH = 17,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    output logic                  o_Full,
    input  logic                  i_Data_Valid,
    input  logic [DATA_WIDTH-1:0] i_Data,
    output logic                  o_Empty,
    input  logic                  i_Read,
    output logic [DATA_WIDTH-1:0] o_Data,
    output logic [1:0]            o_Diag_State,
    output logic [ADDR_WIDTH-1:0] o_Diag_Buf_W_Addr,
    output logic [ADDR_WIDTH-1:0] o_Diag_Buf_R_Addr
);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_w_addr;
    logic [ADDR_WIDTH-1:0] r_r_addr;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_wr_en;
    logic                  w_rd_en;
    logic [ADDR_WIDTH-1:0] w_w_addr_nxt;
    logic [ADDR_WIDTH-1:0] w_r_addr_nxt;

    // Accept decisions use the pre-edge state. Writes are refused when full
    // and reads are refused when empty, which covers simultaneous requests.
    assign w_wr_en      = i_Data_Valid && (r_state != ST_FULL);
    assign w_rd_en      = i_Read && (r_state != ST_EMPTY);
    assign w_w_addr_nxt = r_w_addr + ADDR_WIDTH'(1);
    assign w_r_addr_nxt = r_r_addr + ADDR_WIDTH'(1);

    // State and pointers; pointers wrap naturally modulo DEPTH
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_state  <= ST_EMPTY;
            r_w_addr <= '0;
            r_r_addr <= '0;
        end else begin
            if (w_wr_en) r_w_addr <= w_w_addr_nxt;
            if (w_rd_en) r_r_addr <= w_r_addr_nxt;
            case (r_state)
                ST_EMPTY: begin
                    if (w_wr_en) r_state <= ST_PARTIAL;
                end
                ST_PARTIAL: begin
                    // A simultaneous write and read leaves the occupancy unchanged
                    if (w_wr_en && !w_rd_en && (w_w_addr_nxt == r_r_addr))
                        r_state <= ST_FULL;
                    else if (w_rd_en && !w_wr_en && (w_r_addr_nxt == r_w_addr))
                        r_state <= ST_EMPTY;
                end
                ST_FULL: begin
                    if (w_rd_en) r_state <= ST_PARTIAL;
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    // Storage words; each word is cleared on reset
    for (genvar g = 0; g < DEPTH; g++) begin : g_mem
        always_ff @(posedge i_Clk or negedge i_Rst) begin
            if (!i_Rst)
                r_mem[g] <= '0;
            else if (w_wr_en && (r_w_addr == ADDR_WIDTH'(g)))
                r_mem[g] <= i_Data;
        end
    end

    assign o_Data  = r_mem[r_r_addr];
    assign o_Empty = (r_state == ST_EMPTY);
    assign o_Full  = (r_state == ST_FULL);

`ifdef FIFO_DIAG_EN
    assign o_Diag_State      = r_state;
    assign o_Diag_Buf_W_Addr = r_w_addr;
    assign o_Diag_Buf_R_Addr = r_r_addr;
`else
    assign o_Diag_State      = 2'd0;
    assign o_Diag_Buf_W_Addr = '0;
    assign o_Diag_Buf_R_Addr = '0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo. A queue-based model predicts every
// output; directed literal checks pin the model at known points.
module tb_sync_fifo;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = 17;
    localparam int unsigned AW    = 2;
`ifdef FIFO_DIAG_EN
    localparam bit DIAG = 1'b1;
`else
    localparam bit DIAG = 1'b0;
`endif

    logic          i_Clk;
    logic          i_Rst;
    logic          i_Data_Valid;
    logic [DW-1:0] i_Data;
    logic          i_Read;
    logic          o_Full;
    logic          o_Empty;
    logic [DW-1:0] o_Data;
    logic [1:0]    o_Diag_State;
    logic [AW-1:0] o_Diag_Buf_W_Addr;
    logic [AW-1:0] o_Diag_Buf_R_Addr;

    sync_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .i_Clk             (i_Clk),
        .i_Rst             (i_Rst),
        .o_Full            (o_Full),
        .i_Data_Valid      (i_Data_Valid),
        .i_Data            (i_Data),
        .o_Empty           (o_Empty),
        .i_Read            (i_Read),
        .o_Data            (o_Data),
        .o_Diag_State      (o_Diag_State),
        .o_Diag_Buf_W_Addr (o_Diag_Buf_W_Addr),
        .o_Diag_Buf_R_Addr (o_Diag_Buf_R_Addr)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queue of stored words plus counts of accepted writes and reads
    logic [DW-1:0] q[$];
    int unsigned   wcnt = 0;
    int unsigned   rcnt = 0;

    always @(posedge i_Clk) begin : m_model
        bit wr;
        bit rd;
        if (i_Rst) begin
            wr = i_Data_Valid && (q.size() < DEPTH);
            rd = i_Read && (q.size() > 0);
            if (rd) begin
                void'(q.pop_front());
                rcnt++;
            end
            if (wr) begin
                q.push_back(i_Data);
                wcnt++;
            end
        end
    end

    always @(negedge i_Rst) begin
        q.delete();
        wcnt = 0;
        rcnt = 0;
    end

    // Per-cycle comparison against the model
    always @(negedge i_Clk) begin : m_compare
        int unsigned exp_st;
        exp_st = (q.size() == 0) ? 0 : ((q.size() == DEPTH) ? 2 : 1);
        check("m_empty", 32'(o_Empty), 32'(q.size() == 0));
        check("m_full", 32'(o_Full), 32'(q.size() == DEPTH));
        if (q.size() != 0) check("m_data", 32'(o_Data), 32'(q[0]));
        check("m_state", 32'(o_Diag_State), DIAG ? exp_st : 0);
        check("m_waddr", 32'(o_Diag_Buf_W_Addr), DIAG ? (wcnt % DEPTH) : 0);
        check("m_raddr", 32'(o_Diag_Buf_R_Addr), DIAG ? (rcnt % DEPTH) : 0);
    end

    task automatic check_diag(input string tag, input int unsigned st,
                              input int unsigned wa, input int unsigned ra);
        check({tag, "_state"}, 32'(o_Diag_State), DIAG ? st : 0);
        check({tag, "_waddr"}, 32'(o_Diag_Buf_W_Addr), DIAG ? wa : 0);
        check({tag, "_raddr"}, 32'(o_Diag_Buf_R_Addr), DIAG ? ra : 0);
    endtask

    // Drive one cycle of strobes, then settle just after the edge
    task automatic step(input logic v, input logic [DW-1:0] d, input logic r);
        i_Data_Valid = v;
        i_Data       = d;
        i_Read       = r;
        @(posedge i_Clk);
        #1;
        i_Data_Valid = 1'b0;
        i_Read       = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] dcnt;
        i_Rst        = 1'b0;
        i_Data_Valid = 1'b0;
        i_Data       = '0;
        i_Read       = 1'b0;

        // Reset state
        repeat (2) @(posedge i_Clk);
        #1;
        check("rst_empty", 32'(o_Empty), 32'd1);
        check("rst_full", 32'(o_Full), 32'd0);
        check("rst_data", 32'(o_Data), 32'd0);
        check_diag("rst", 0, 0, 0);
        @(negedge i_Clk);
        i_Rst = 1'b1;
        @(posedge i_Clk);
        #1;

        // Fill with 1..4
        step(1'b1, 17'd1, 1'b0);
        check("w1_empty", 32'(o_Empty), 32'd0);
        check("w1_data", 32'(o_Data), 32'd1);
        step(1'b1, 17'd2, 1'b0);
        step(1'b1, 17'd3, 1'b0);
        step(1'b1, 17'd4, 1'b0);
        check("w4_full", 32'(o_Full), 32'd1);
        check_diag("w4", 2, 0, 0);

        // Write while full is dropped, then drain
        step(1'b1, 17'd5, 1'b0);
        check("wf_full", 32'(o_Full), 32'd1);
        check("wf_data", 32'(o_Data), 32'd1);
        check_diag("wf", 2, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            check("rd_data", 32'(o_Data), 32'(k));
            step(1'b0, '0, 1'b1);
        end
        check("rd_empty", 32'(o_Empty), 32'd1);
        check_diag("rd", 0, 0, 0);

        // Write and read together while empty: only the write happens
        step(1'b1, 17'd10, 1'b1);
        check("ewr_empty", 32'(o_Empty), 32'd0);
        check("ewr_data", 32'(o_Data), 32'd10);
        check_diag("ewr", 1, 1, 0);

        // Two words held, then six simultaneous write/read cycles
        step(1'b1, 17'd11, 1'b0);
        for (int i = 0; i < 6; i++) begin
            check("sim_data", 32'(o_Data), 32'(10 + i));
            step(1'b1, 17'(12 + i), 1'b1);
            check("sim_empty", 32'(o_Empty), 32'd0);
            check("sim_full", 32'(o_Full), 32'd0);
        end
        check("sim_end_data", 32'(o_Data), 32'd16);
        check_diag("sim", 1, 0, 2);

        // Fill up, then write and read together while full: only the read happens
        step(1'b1, 17'd18, 1'b0);
        step(1'b1, 17'd19, 1'b0);
        check("f2_full", 32'(o_Full), 32'd1);
        check_diag("f2", 2, 2, 2);
        step(1'b1, 17'd99, 1'b1);
        check("fwr_full", 32'(o_Full), 32'd0);
        check("fwr_data", 32'(o_Data), 32'd17);
        check_diag("fwr", 1, 2, 3);

        // Random producer/consumer gaps with a reset pulse mid-stream
        dcnt = 17'd100;
        for (int i = 0; i < 200; i++) begin
            if (i == 100) begin
                i_Rst = 1'b0;
                #1;
                check("mrst_empty", 32'(o_Empty), 32'd1);
                check("mrst_data", 32'(o_Data), 32'd0);
                check_diag("mrst", 0, 0, 0);
                @(posedge i_Clk);
                @(negedge i_Clk);
                i_Rst = 1'b1;
                @(posedge i_Clk);
                #1;
            end
            step(1'($urandom_range(0, 1)), dcnt, 1'($urandom_range(0, 1)));
            dcnt = dcnt + DW'(1);
        end

        // Drain what remains
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);
        check("end_empty", 32'(o_Empty), 32'd1);

        @(negedge i_Clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock first-word-fall-through FIFO that buffers DATA_WIDTH-bit words between a producer and a consumer in the same clock domain; used in the TM1638 display path to queue command/data words ahead of the serial driver. The head word is always presented on o_Data while the FIFO is non-empty, and i_Read pops it. Diagnostic outputs expose the internal state and buffer pointers for debug and verification.

## Interface
- DEPTH, 4: number of storage words; power of two, at least 2.
- DATA_WIDTH, 17: word width in bits.
- ADDR_WIDTH, $clog2(DEPTH): pointer width.

- i_Clk  in  1  clock; all state updates on the rising edge.
- i_Rst  in  1  asynchronous, active-low reset.
- o_Full  out  1  1 when DEPTH words are stored.
- i_Data_Valid  in  1  write strobe; one word written per cycle while high.
- i_Data  in  DATA_WIDTH  write data.
- o_Empty  out  1  1 when no words are stored.
- i_Read  in  1  pop strobe; removes the head word per cycle while high.
- o_Data  out  DATA_WIDTH  head word (oldest stored).
- o_Diag_State  out  2  0=EMPTY, 1=PARTIAL, 2=FULL; 3 unused.
- o_Diag_Buf_W_Addr  out  ADDR_WIDTH  next write slot.
- o_Diag_Buf_R_Addr  out  ADDR_WIDTH  head slot.

## Operation
- Storage: DEPTH x DATA_WIDTH register array; W_Addr and R_Addr ADDR_WIDTH bits each, incrementing modulo DEPTH; wrap from DEPTH-1 to 0 is natural overflow.
- Write accepted at an edge iff i_Data_Valid=1 and o_Full=0 (pre-edge value): mem[W_Addr] <= i_Data, W_Addr++.
- Read accepted at an edge iff i_Read=1 and o_Empty=0 (pre-edge value): R_Addr++.
- Write while full is dropped: no pointer or data change. Read while empty is ignored.
- State machine, 2-bit register:
  - EMPTY: write only goes to PARTIAL; write and read together is write only (read ignored), so the state becomes PARTIAL.
  - PARTIAL: write only goes to FULL if W_Addr+1 == R_Addr, else stays PARTIAL; read only goes to EMPTY if R_Addr+1 == W_Addr, else stays PARTIAL; write and read together keeps PARTIAL with both pointers advancing.
  - FULL: read goes to PARTIAL; write and read together is read only (write dropped), so the state becomes PARTIAL.
- o_Empty = (state==EMPTY); o_Full = (state==FULL); both decoded from the state register, glitch-free.
- o_Data = mem[R_Addr], an asynchronous read of the array. Valid only when o_Empty=0; otherwise it shows the stale slot contents.
- Reset (i_Rst=0, asynchronous): state=EMPTY, W_Addr=R_Addr=0, every array word cleared to 0. Outputs are o_Empty=1, o_Full=0, o_Data=0, o_Diag_State=0, and both diagnostic addresses 0. A mid-operation reset discards all contents immediately.

## Timing
- Write latency: a word written at edge N appears on o_Data after edge N when the FIFO was empty; o_Empty falls after edge N.
- Read: o_Data shows the head before the pop; the next word, or stale data with o_Empty=1, is presented after the popping edge.
- Flags update only at rising edges or asynchronous reset; no combinational path from i_Data_Valid or i_Read to any output.
- Throughput: one write and one read per cycle sustained in PARTIAL.
- Reset deassertion takes effect synchronously to the next rising edge; no operation occurs on the deasserting edge if recovery is violated (integrator responsibility).

## Configuration
- FIFO_DIAG_EN defined: o_Diag_State, o_Diag_Buf_W_Addr and o_Diag_Buf_R_Addr drive the live state and pointer values.
- FIFO_DIAG_EN undefined: the ports remain, and all three are tied to constant 0. FIFO function is unchanged.

## Test plan
- Reset, then check after two cycles → o_Empty=1, o_Full=0, o_Diag_State=0, W_Addr=0, R_Addr=0, o_Data=0.
- Write 1,2,3,4 on consecutive cycles, no reads → o_Empty=0 after the first edge, o_Data=1, o_Full=1 and State=2 after the fourth edge, W_Addr wrapped to 0.
- Full, then write 5 → write dropped, W_Addr=0; then read 4 times → o_Data sequence 1,2,3,4, then o_Empty=1 and R_Addr=0.
- Hold 2 words, assert i_Data_Valid and i_Read together for 6 cycles with incrementing data → State stays 1, pointers wrap, output order strictly incrementing with no loss.
- Empty, write and read together → write taken, read ignored; o_Empty=0 and the new word is on o_Data. Full, write and read together → read taken, write dropped; State=1.
- Random producer/consumer gaps over 2000 ns with incrementing data, with i_Rst pulsed low mid-stream → after each reset the FIFO is empty with both pointers 0; the order checker restarts and no mismatches occur.
